sev_seg_decoder: RTL and testbench
==================================

SEV_SEG_DECODER -- requirements
Module: sev_seg_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: consecutive identical synchronized samples required before a digit is accepted; legal range 2..65535.
REQ-002 clk  input  1  single clock; every flop is on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 an_in  input  4  multiplexed anode lines, active-low; an_in[0] selects the low nibble, an_in[1] the high nibble; an_in[3:2] unused and expected high.
REQ-005 seg_in  input  7  segment lines, active-low, bit order {g,f,e,d,c,b,a} (bit 0 = a).
REQ-006 num  output  8  most recently assembled byte, {high nibble, low nibble}.
REQ-007 num_valid  output  1  one-cycle pulse on the edge that updates num.
REQ-008 pattern_err  output  1  one-cycle pulse when a stable, selected digit carries an undecodable segment pattern.

Function
REQ-009 an_in and seg_in SHALL each pass through a two-flop synchronizer before use; all later references mean the synchronized sample S = {an, seg}.
REQ-010 Selection: the digit is LOW when an == 4'b1110 and HIGH when an == 4'b1101; any other an value is NONE.
REQ-011 Controller states: IDLE, SETTLE, HELD.
REQ-012 IDLE: stays in IDLE while the selection is NONE; on LOW or HIGH, load the stability counter with 1, latch S, and go to SETTLE.
REQ-013 SETTLE: if S differs from the latched S, reload the counter with 1 and relatch S; if the selection becomes NONE, go to IDLE; otherwise increment the counter.
REQ-014 SETTLE to HELD: on the edge where the counter would reach STABLE_CYCLES, evaluate the digit exactly once.
REQ-015 HELD: no further evaluation; a change of S returns to SETTLE with a counter of 1, or to IDLE if the selection is NONE.
REQ-016 Decode table (seg value to nibble): 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F.
REQ-017 Any other seg value at evaluation: pulse pattern_err; the nibble is not stored; the pending flag for that position is cleared.
REQ-018 On a valid evaluation, store the nibble in the low or high holding register and set that position's pending flag.
REQ-019 Once both pending flags are set, num is loaded from the holding registers on that same edge, num_valid pulses (subject to REQ-026), and both flags clear. Evaluation order does not matter.
REQ-020 Re-evaluating a position that is already pending overwrites its holding register; the flag stays set.
REQ-021 Latency: num_valid is asserted no earlier than 2 + STABLE_CYCLES clocks after the completing digit's inputs settle.
REQ-022 num_valid and pattern_err are never asserted on the same edge for the same evaluation.

Reset
REQ-023 While rst is high: num = 8'h00, num_valid = 0, pattern_err = 0, state = IDLE, counter = 0, holding registers = 0, pending flags = 0, and the synchronizers load 1s (all lines inactive).
REQ-024 Reset asserted mid-SETTLE or with one flag pending discards all partial progress; no pulse is emitted at or after deassertion until a fresh pair is accepted.
REQ-025 Deassertion is released synchronously to clk before it reaches the state machine.

Configuration
REQ-026 Macro SEVSEG_DEC_ONCHANGE_EN defined: num_valid pulses only if the assembled byte differs from the current num; the first completed pair after reset always pulses. num is still rewritten either way.
REQ-027 Macro SEVSEG_DEC_ONCHANGE_EN undefined: every completed pair pulses num_valid.

Verification (STABLE_CYCLES = 4)
REQ-028 Alternate an=1110/seg=0010010 and an=1101/seg=0110000, each held 10 cycles -> num=8'h35, one num_valid pulse per completed pair.
REQ-029 Hold the low digit for 3 cycles only, then present the high digit -> no evaluation of the low digit; no num_valid until the low digit is held at least 4 cycles.
REQ-030 Stable low digit with seg=1111111 -> pattern_err pulses once; num is unchanged; no num_valid.
REQ-031 an=1100 or an=1111 for 50 cycles -> state stays IDLE; no pulses.
REQ-032 Repeat the 8'h35 pattern with the macro on -> exactly one num_valid; with the macro off -> one pulse per pair.
REQ-033 Assert rst after the low digit is accepted, then present only the high digit -> no num_valid; num = 8'h00.

Source files
------------

// File: rtl/sev_seg_decoder.sv
// Seven-segment display snooper: decodes a multiplexed two-digit, active-low display back into a byte.
// Optional build macro SEVSEG_DEC_ONCHANGE_EN: num_valid pulses only when the assembled byte changes.
module sev_seg_decoder #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an_in,
  input  logic [6:0] seg_in,
  output logic [7:0] num,
  output logic       num_valid,
  output logic       pattern_err
);

  localparam int unsigned     CW   = 16;
  localparam logic [CW-1:0]   LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [10:0]     IDLE_LINES = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_LOW, SEL_HIGH} sel_t;

  function automatic sel_t sel_of(input logic [3:0] an);
    if (an == 4'b1110)      sel_of = SEL_LOW;
    else if (an == 4'b1101) sel_of = SEL_HIGH;
    else                    sel_of = SEL_NONE;
  endfunction

  // Returns {valid, nibble}; segment patterns are active-low {g,f,e,d,c,b,a}.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      7'b0001000: decode = 5'h1a;
      7'b0000011: decode = 5'h1b;
      7'b1000110: decode = 5'h1c;
      7'b0100001: decode = 5'h1d;
      7'b0000110: decode = 5'h1e;
      7'b0001110: decode = 5'h1f;
      default:    decode = 5'h00;
    endcase
  endfunction

  // Reset asserts immediately but releases two edges later, aligned to clk.
  logic [1:0] rst_sync;
  logic       rst_i;

  // NOTE: every clocked process uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_i = rst_sync[1];

  logic [10:0] s_meta, s_cur;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      s_meta <= IDLE_LINES;
      s_cur  <= IDLE_LINES;
    end else begin
      s_meta <= {an_in, seg_in};
      s_cur  <= s_meta;
    end
  end

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [10:0]     lat_q, lat_d;
  logic            eval;
  sel_t            cur_sel;

  assign cur_sel = sel_of(s_cur[10:7]);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= IDLE_LINES;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end

  // NOTE: defaults first so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    eval    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cur_sel != SEL_NONE) begin
          cnt_d   = CW'(1);
          lat_d   = s_cur;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cur_sel == SEL_NONE) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (s_cur != lat_q) begin
          cnt_d = CW'(1);
          lat_d = s_cur;
        end else if (cnt_q == LAST) begin
          cnt_d   = CW'(STABLE_CYCLES);
          eval    = 1'b1;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (cur_sel == SEL_NONE) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (s_cur != lat_q) begin
          cnt_d   = CW'(1);
          lat_d   = s_cur;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Evaluation works on the latched sample, which equals s_cur on the evaluating edge.
  logic [4:0] dec;
  logic       is_low;
  logic [3:0] hold_lo, hold_hi, lo_n, hi_n;
  logic       pend_lo, pend_hi, other_pend;

  assign dec        = decode(lat_q[6:0]);
  assign is_low     = (sel_of(lat_q[10:7]) == SEL_LOW);
  assign lo_n       = is_low ? dec[3:0] : hold_lo;
  assign hi_n       = is_low ? hold_hi  : dec[3:0];
  assign other_pend = is_low ? pend_hi  : pend_lo;

`ifdef SEVSEG_DEC_ONCHANGE_EN
  logic seen_q;
`endif

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      num         <= '0;
      num_valid   <= 1'b0;
      pattern_err <= 1'b0;
      hold_lo     <= '0;
      hold_hi     <= '0;
      pend_lo     <= 1'b0;
      pend_hi     <= 1'b0;
`ifdef SEVSEG_DEC_ONCHANGE_EN
      seen_q      <= 1'b0;
`endif
    end else begin
      num_valid   <= 1'b0;
      pattern_err <= 1'b0;
      if (eval) begin
        if (!dec[4]) begin
          pattern_err <= 1'b1;
          if (is_low) pend_lo <= 1'b0;
          else        pend_hi <= 1'b0;
        end else begin
          hold_lo <= lo_n;
          hold_hi <= hi_n;
          if (other_pend) begin
            num     <= {hi_n, lo_n};
            pend_lo <= 1'b0;
            pend_hi <= 1'b0;
`ifdef SEVSEG_DEC_ONCHANGE_EN
            num_valid <= !seen_q || ({hi_n, lo_n} != num);
            seen_q    <= 1'b1;
`else
            num_valid <= 1'b1;
`endif
          end else if (is_low) begin
            pend_lo <= 1'b1;
          end else begin
            pend_hi <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sev_seg_decoder.sv
// Self-checking bench for sev_seg_decoder (STABLE_CYCLES = 4) against a run-length reference model.
module tb_sev_seg_decoder;

  localparam int N = 4;
  localparam logic [3:0] AN_LO = 4'b1110;
  localparam logic [3:0] AN_HI = 4'b1101;
  localparam logic [3:0] AN_NO = 4'b1111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] an_in = AN_NO;
  logic [6:0] seg_in = 7'h7f;
  logic [7:0] num;
  logic       num_valid;
  logic       pattern_err;

  sev_seg_decoder #(.STABLE_CYCLES(N)) dut (
    .clk(clk), .rst(rst), .an_in(an_in), .seg_in(seg_in),
    .num(num), .num_valid(num_valid), .pattern_err(pattern_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the decoder sees inputs two edges late, and evaluates a selected
  // digit once its run of identical samples reaches exactly N.
  logic [6:0]  seg_tab [16];
  logic [10:0] q1, q2, run_val;
  int          run_len;
  logic [3:0]  m_hold [2];
  logic        m_pend [2];
  logic [7:0]  m_num;
  logic        m_seen;
  logic        exp_valid, exp_err;
  int          obs_valid, obs_err, m_valid_cnt, mism;
  string       first_mism;

  task automatic model_reset();
    q1 = {AN_NO, 7'h7f};
    q2 = q1;
    run_val = q1;
    run_len = 1000;
    m_hold[0] = 4'h0; m_hold[1] = 4'h0;
    m_pend[0] = 1'b0; m_pend[1] = 1'b0;
    m_num = 8'h00;
    m_seen = 1'b0;
  endtask

  task automatic model_eval(input logic [10:0] smp);
    int pos, nib;
    logic [7:0] b;
    pos = (smp[10:7] == AN_LO) ? 0 : 1;
    nib = -1;
    for (int i = 0; i < 16; i++) if (seg_tab[i] == smp[6:0]) nib = i;
    if (nib < 0) begin
      exp_err = 1'b1;
      m_pend[pos] = 1'b0;
    end else begin
      m_hold[pos] = 4'(nib);
      m_pend[pos] = 1'b1;
      if (m_pend[0] && m_pend[1]) begin
        b = {m_hold[1], m_hold[0]};
`ifdef SEVSEG_DEC_ONCHANGE_EN
        exp_valid = !m_seen || (b != m_num);
`else
        exp_valid = 1'b1;
`endif
        m_seen = 1'b1;
        m_num = b;
        m_pend[0] = 1'b0;
        m_pend[1] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [10:0] smp;
    @(posedge clk);
    smp = q2;
    q2 = q1;
    q1 = {an_in, seg_in};
    exp_valid = 1'b0;
    exp_err = 1'b0;
    if (smp == run_val) run_len++;
    else begin
      run_val = smp;
      run_len = 1;
    end
    if ((smp[10:7] == AN_LO || smp[10:7] == AN_HI) && run_len == N) model_eval(smp);
    if (exp_valid) m_valid_cnt++;
    #1;
    if (num_valid) obs_valid++;
    if (pattern_err) obs_err++;
    if (num_valid !== exp_valid || pattern_err !== exp_err || num !== m_num) begin
      if (mism == 0)
        first_mism = $sformatf("t=%0t num=%h/%h valid=%b/%b err=%b/%b", $time,
                               num, m_num, num_valid, exp_valid, pattern_err, exp_err);
      mism++;
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an_in = a;
    seg_in = s;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (num !== 8'h00) begin errors++; $display("FAIL reset_num: got %h want 00", num); end
    checks++; if (num_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", num_valid); end
    checks++; if (pattern_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", pattern_err); end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_pair_35();
    int v0, m0, want;
    v0 = obs_valid; m0 = mism;
    hold(AN_NO, 7'h7f, 4);
    for (int i = 0; i < 3; i++) begin
      hold(AN_LO, 7'b0010010, 10);
      hold(AN_HI, 7'b0110000, 10);
    end
    hold(AN_NO, 7'h7f, 4);
`ifdef SEVSEG_DEC_ONCHANGE_EN
    want = 1;
`else
    want = 3;
`endif
    checks++; if (num !== 8'h35) begin errors++; $display("FAIL pair35_num: got %h want 35", num); end
    checks++; if (obs_valid - v0 !== want) begin errors++; $display("FAIL pair35_pulses: got %0d want %0d", obs_valid - v0, want); end
    checks++; if (mism !== m0) begin errors++; $display("FAIL pair35_model: %s", first_mism); end
  endtask

  task automatic test_short_hold();
    int v0, e0;
    v0 = obs_valid; e0 = obs_err;
    hold(AN_LO, 7'b1111000, 3);
    hold(AN_HI, 7'b0100100, 10);
    hold(AN_NO, 7'h7f, 4);
    checks++; if (obs_valid - v0 !== 0) begin errors++; $display("FAIL short_no_pulse: got %0d want 0", obs_valid - v0); end
    checks++; if (obs_err - e0 !== 0) begin errors++; $display("FAIL short_no_err: got %0d want 0", obs_err - e0); end
    hold(AN_LO, 7'b1111000, N);
    hold(AN_NO, 7'h7f, 6);
    checks++; if (obs_valid - v0 !== 1) begin errors++; $display("FAIL short_then_full: got %0d want 1", obs_valid - v0); end
    checks++; if (num !== 8'h27) begin errors++; $display("FAIL short_num: got %h want 27", num); end
  endtask

  task automatic test_bad_pattern();
    int v0, e0;
    v0 = obs_valid; e0 = obs_err;
    hold(AN_LO, 7'b1111111, 10);
    hold(AN_NO, 7'h7f, 4);
    checks++; if (obs_err - e0 !== 1) begin errors++; $display("FAIL bad_err_count: got %0d want 1", obs_err - e0); end
    checks++; if (obs_valid - v0 !== 0) begin errors++; $display("FAIL bad_no_valid: got %0d want 0", obs_valid - v0); end
    checks++; if (num !== 8'h27) begin errors++; $display("FAIL bad_num_kept: got %h want 27", num); end
  endtask

  task automatic test_none_select();
    int v0, e0;
    v0 = obs_valid; e0 = obs_err;
    for (int i = 0; i < 5; i++) hold(4'b1100, seg_tab[$urandom_range(0, 15)], 10);
    for (int i = 0; i < 5; i++) hold(AN_NO, seg_tab[$urandom_range(0, 15)], 10);
    checks++; if (obs_valid - v0 !== 0) begin errors++; $display("FAIL none_valid: got %0d want 0", obs_valid - v0); end
    checks++; if (obs_err - e0 !== 0) begin errors++; $display("FAIL none_err: got %0d want 0", obs_err - e0); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = obs_valid;
    hold(AN_LO, 7'b1111001, 8);
    hold(AN_LO, 7'b0010000, 8);
    hold(AN_HI, 7'b0011001, 8);
    hold(AN_NO, 7'h7f, 4);
    checks++; if (num !== 8'h49) begin errors++; $display("FAIL b2b_num: got %h want 49", num); end
    checks++; if (obs_valid - v0 !== 1) begin errors++; $display("FAIL b2b_pulses: got %0d want 1", obs_valid - v0); end
  endtask

  task automatic test_random();
    int m0, v0, mv0, pick;
    logic [3:0] a;
    logic [6:0] s;
    m0 = mism; v0 = obs_valid; mv0 = m_valid_cnt;
    for (int i = 0; i < 250; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 4)      a = AN_LO;
      else if (pick < 8) a = AN_HI;
      else if (pick == 8) a = AN_NO;
      else               a = 4'b1100;
      s = ($urandom_range(0, 9) < 8) ? seg_tab[$urandom_range(0, 15)] : 7'($urandom);
      hold(a, s, $urandom_range(1, 9));
    end
    hold(AN_NO, 7'h7f, 4);
    checks++; if (mism !== m0) begin errors++; $display("FAIL random_model: %0d cycles differ, first %s", mism - m0, first_mism); end
    checks++; if (obs_valid - v0 !== m_valid_cnt - mv0) begin errors++; $display("FAIL random_pulses: got %0d want %0d", obs_valid - v0, m_valid_cnt - mv0); end
  endtask

  task automatic test_reset_partial();
    int v0, stray;
    stray = 0;
    hold(AN_NO, 7'h7f, 4);
    hold(AN_LO, 7'b0000010, 10);
    #3 rst = 1'b1;
    #1;
    checks++; if (num !== 8'h00 || num_valid !== 1'b0 || pattern_err !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got %h/%b/%b want 00/0/0", num, num_valid, pattern_err);
    end
    an_in = AN_NO; seg_in = 7'h7f;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (num_valid || pattern_err) stray++;
    end
    model_reset();
    v0 = obs_valid;
    hold(AN_HI, 7'b0000000, 10);
    hold(AN_NO, 7'h7f, 4);
    checks++; if (stray !== 0) begin errors++; $display("FAIL release_pulse: got %0d want 0", stray); end
    checks++; if (obs_valid - v0 !== 0) begin errors++; $display("FAIL partial_discard: got %0d want 0", obs_valid - v0); end
    checks++; if (num !== 8'h00) begin errors++; $display("FAIL partial_num: got %h want 00", num); end
    hold(AN_LO, 7'b1000000, 10);
    hold(AN_NO, 7'h7f, 4);
    checks++; if (obs_valid - v0 !== 1) begin errors++; $display("FAIL fresh_pair_pulse: got %0d want 1", obs_valid - v0); end
    checks++; if (num !== 8'h80) begin errors++; $display("FAIL fresh_pair_num: got %h want 80", num); end
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    obs_valid = 0; obs_err = 0; m_valid_cnt = 0; mism = 0;
    first_mism = "";
    model_reset();
    test_reset();
    test_pair_35();
    test_short_hold();
    test_bad_pattern();
    test_none_select();
    test_back_to_back();
    test_random();
    test_reset_partial();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
